// File: rtl/count_chk_pkg.sv
// Shared definitions for the count sequence checker: FSM state encoding
// and the value the upstream counter shows while it is held in reset.
package count_chk_pkg;

    localparam logic [1:0] ENC_HUNT   = 2'd0;
    localparam logic [1:0] ENC_LOCKED = 2'd1;
    localparam logic [1:0] ENC_ERROR  = 2'd2;

    typedef enum logic [1:0] {
        ST_HUNT   = ENC_HUNT,
        ST_LOCKED = ENC_LOCKED,
        ST_ERROR  = ENC_ERROR
    } state_t;

    // Upstream counter output while that counter sits in reset
    localparam logic [3:0] CNT_RST_VAL = 4'hF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, stick at all-ones, clear on clr or rst
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// Watches an upstream mod-(MAX_COUNT+1) counter: locks onto the first 0,
// counts legal MAX_COUNT->0 wraps and flags any out-of-sequence value.
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int MAX_COUNT = 8,
    parameter int WRAP_W    = 8,
    parameter int ERR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        count_in,
    input  logic              clr_err,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              locked,
    output logic              seq_err,
    output logic [ERR_W-1:0]  err_count,
    output logic [1:0]        state
);

    localparam logic [3:0] MAX_VAL = 4'(MAX_COUNT);

    state_t            cur_state;
    state_t            state_nxt;
    logic [3:0]        prev;
    logic [3:0]        prev_nxt;
    logic [3:0]        expected;
    logic              pulse_nxt;
    logic [WRAP_W-1:0] wrap_nxt;
    logic              seq_nxt;
    logic              err_inc;

    // Value the upstream counter must show next while locked
    assign expected = (prev == MAX_VAL) ? 4'd0 : prev + 4'd1;

    // Next-state and next-output decode
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nxt = cur_state;
        prev_nxt  = prev;
        pulse_nxt = 1'b0;
        wrap_nxt  = wrap_count;
        seq_nxt   = seq_err;
        err_inc   = 1'b0;

        case (cur_state)
            ST_HUNT: begin
                // Anything but 0 (including CNT_RST_VAL) is ignored here
                if (count_in == 4'd0) begin
                    state_nxt = ST_LOCKED;
                    prev_nxt  = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (count_in == expected) begin
                    prev_nxt = count_in;
                    if (prev == MAX_VAL) begin
                        pulse_nxt = 1'b1;
                        wrap_nxt  = wrap_count + WRAP_W'(1);
                    end
                end else begin
                    state_nxt = ST_ERROR;
                    seq_nxt   = 1'b1;
                    err_inc   = 1'b1;
                end
            end
            ST_ERROR: begin
                if (clr_err) begin
                    state_nxt = ST_HUNT;
                end
            end
            default: begin
                state_nxt = ST_HUNT;
            end
        endcase

        // Clear wins over a same-cycle violation for the error flag
        if (clr_err) begin
            seq_nxt = 1'b0;
        end
    end

    // State, history and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= ST_HUNT;
            prev       <= 4'd0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            locked     <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            cur_state  <= state_nxt;
            prev       <= prev_nxt;
            wrap_pulse <= pulse_nxt;
            wrap_count <= wrap_nxt;
            locked     <= (state_nxt == ST_LOCKED);
            seq_err    <= seq_nxt;
        end
    end

    assign state = cur_state;

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .clr   (clr_err),
        .count (err_count)
    );

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker with hand-computed expectations.
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count_in = 4'd0;
    logic       clr_err = 1'b0;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       locked;
    logic       seq_err;
    logic [3:0] err_count;
    logic [1:0] state;

    logic       sat_inc = 1'b0;
    logic       sat_clr = 1'b0;
    logic [3:0] sat_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_seq_checker #(
        .MAX_COUNT (8),
        .WRAP_W    (8),
        .ERR_W     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .clr_err    (clr_err),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .locked     (locked),
        .seq_err    (seq_err),
        .err_count  (err_count),
        .state      (state)
    );

    // Standalone saturating counter: the checker itself cannot accumulate
    // more than one violation before a clear, so saturation is shown here.
    sat_counter #(
        .WIDTH (4)
    ) u_sat (
        .clk   (clk),
        .rst   (rst),
        .inc   (sat_inc),
        .clr   (sat_clr),
        .count (sat_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample, let it be clocked, settle just after the edge
    task automatic step(input logic [3:0] c, input logic clr);
        count_in = c;
        clr_err  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(4'd0, 1'b0);
        rst = 1'b0;
    endtask

    int pulses;
    int bad_pulses;

    initial begin
        // Reset state
        do_reset();
        check("rst_state", state, 0);
        check("rst_locked", locked, 0);
        check("rst_wrap_count", wrap_count, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_wrap_pulse", wrap_pulse, 0);

        // 15,0,1..8,0 : lock after first 0, single wrap after second 0
        step(4'hF, 1'b0);
        check("hunt_ignore_f_state", state, 0);
        check("hunt_ignore_f_err", seq_err, 0);
        step(4'd0, 1'b0);
        check("lock_locked", locked, 1);
        check("lock_state", state, 1);
        bad_pulses = 0;
        for (int v = 1; v <= 8; v++) begin
            step(4'(v), 1'b0);
            if (wrap_pulse) bad_pulses++;
        end
        check("no_pulse_before_wrap", bad_pulses, 0);
        step(4'd0, 1'b0);
        check("wrap1_pulse", wrap_pulse, 1);
        check("wrap1_count", wrap_count, 1);
        check("wrap1_seq_err", seq_err, 0);
        step(4'd1, 1'b0);
        check("wrap1_pulse_drop", wrap_pulse, 0);

        // 300 wraps from a fresh lock: 300 mod 256 = 44
        do_reset();
        step(4'd0, 1'b0);
        pulses = 0;
        bad_pulses = 0;
        for (int w = 0; w < 300; w++) begin
            for (int v = 1; v <= 8; v++) begin
                step(4'(v), 1'b0);
                if (wrap_pulse) bad_pulses++;
            end
            step(4'd0, 1'b0);
            if (wrap_pulse) pulses++;
        end
        check("w300_wrap_count", wrap_count, 44);
        check("w300_pulses", pulses, 300);
        check("w300_stray_pulses", bad_pulses, 0);
        check("w300_seq_err", seq_err, 0);
        check("w300_state", state, 1);

        // Locked at prev=4, drive 6 -> ERROR
        for (int v = 1; v <= 4; v++) step(4'(v), 1'b0);
        step(4'd6, 1'b0);
        check("skip_state", state, 2);
        check("skip_seq_err", seq_err, 1);
        check("skip_err_count", err_count, 1);
        check("skip_locked", locked, 0);
        check("skip_pulse", wrap_pulse, 0);
        step(4'd5, 1'b0);
        step(4'd0, 1'b0);
        step(4'd7, 1'b0);
        step(4'hF, 1'b0);
        check("garbage_err_count", err_count, 1);
        check("garbage_state", state, 2);
        check("garbage_wrap_held", wrap_count, 44);

        // clr_err in ERROR -> HUNT, error cleared, wraps kept
        step(4'd3, 1'b1);
        check("clr_state", state, 0);
        check("clr_err_count", err_count, 0);
        check("clr_seq_err", seq_err, 0);
        check("clr_wrap_kept", wrap_count, 44);

        // clr_err in HUNT does not block normal locking
        step(4'd0, 1'b1);
        check("clr_hunt_lock", state, 1);
        check("clr_hunt_seq_err", seq_err, 0);

        // Upstream reset value while locked -> ERROR
        step(4'd1, 1'b0);
        step(4'hF, 1'b0);
        check("f_inject_state", state, 2);
        check("f_inject_seq_err", seq_err, 1);
        check("f_inject_err_count", err_count, 1);

        // Mismatch with simultaneous clr_err: ERROR but flags clear
        step(4'd0, 1'b1);
        step(4'd0, 1'b0);
        step(4'd1, 1'b0);
        step(4'd2, 1'b0);
        step(4'hF, 1'b1);
        check("sim_clr_state", state, 2);
        check("sim_clr_seq_err", seq_err, 0);
        check("sim_clr_err_count", err_count, 0);

        // Saturation of the error counter block (20 increments, 4 bits)
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        sat_inc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
        end
        sat_inc = 1'b0;
        check("sat_count_15", sat_count, 15);
        sat_inc = 1'b1;
        sat_clr = 1'b1;
        @(posedge clk); #1;
        check("sat_clr_wins", sat_count, 0);
        sat_clr = 1'b0;
        @(posedge clk); #1;
        sat_inc = 1'b0;
        check("sat_one", sat_count, 1);

        // rst while LOCKED with wrap_count=5
        do_reset();
        step(4'd0, 1'b0);
        for (int w = 0; w < 5; w++) begin
            for (int v = 1; v <= 8; v++) step(4'(v), 1'b0);
            step(4'd0, 1'b0);
        end
        check("pre_rst_wrap_count", wrap_count, 5);
        check("pre_rst_locked", locked, 1);
        rst = 1'b1;
        step(4'd1, 1'b1);
        rst = 1'b0;
        check("mid_rst_state", state, 0);
        check("mid_rst_wrap_count", wrap_count, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_pulse", wrap_pulse, 0);
        check("mid_rst_seq_err", seq_err, 0);
        check("mid_rst_err_count", err_count, 0);
        step(4'hF, 1'b0);
        check("relock_f1_state", state, 0);
        step(4'hF, 1'b0);
        check("relock_f2_state", state, 0);
        step(4'd0, 1'b0);
        check("relock_locked", locked, 1);
        check("relock_seq_err", seq_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter MAX_COUNT, default 8: terminal value of the upstream mod-(MAX_COUNT+1) counter; legal range 1..14.
REQ-002 Parameter WRAP_W, default 8: width of wrap_count.
REQ-003 Parameter ERR_W, default 4: width of err_count.
REQ-004 clk  input  1  single clock; all flops rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 count_in  input  4  upstream counter value, sampled every clk edge.
REQ-007 clr_err  input  1  level; releases ERROR state, clears seq_err and err_count.
REQ-008 wrap_pulse  output  1  one-cycle pulse per legal MAX_COUNT->0 transition.
REQ-009 wrap_count  output  WRAP_W  number of legal wraps, modulo 2^WRAP_W.
REQ-010 locked  output  1  high while in LOCKED state.
REQ-011 seq_err  output  1  sticky sequence-violation flag.
REQ-012 err_count  output  ERR_W  violations seen, saturating at all-ones.
REQ-013 state  output  2  current FSM state encoding (HUNT=0, LOCKED=1, ERROR=2).

Function
REQ-014 All outputs SHALL be registered; response to a count_in sample SHALL appear on the cycle after that sample edge.
REQ-015 Internal register prev SHALL hold the last count_in accepted in LOCKED.
REQ-016 HUNT: count_in==0 SHALL move to LOCKED with prev<=0; every other value, including 4'hF (upstream reset value) and values >MAX_COUNT, SHALL be ignored with no error.
REQ-017 LOCKED: expected = (prev==MAX_COUNT) ? 0 : prev+1.
REQ-018 LOCKED, count_in==expected: prev<=count_in; stay LOCKED.
REQ-019 LOCKED, count_in==0 and prev==MAX_COUNT: wrap_pulse<=1 next cycle, wrap_count<=wrap_count+1 wrapping to 0 past all-ones.
REQ-020 LOCKED, count_in!=expected (including 4'hF after upstream reset): move to ERROR, seq_err<=1, err_count increments (saturating); wrap_pulse<=0.
REQ-021 ERROR: further samples ignored; no additional err_count increments; wrap_count held.
REQ-022 ERROR with clr_err==1: move to HUNT, seq_err<=0, err_count<=0; wrap_count retained.
REQ-023 clr_err in HUNT or LOCKED SHALL clear seq_err/err_count without changing state.
REQ-024 Simultaneous clr_err and a LOCKED mismatch: clear wins for seq_err/err_count (both 0), state still moves to ERROR.
REQ-025 wrap_pulse SHALL be low in every cycle not covered by REQ-019.
REQ-026 Unused state encoding 3 SHALL recover to HUNT on the next edge.

Reset
REQ-027 rst high at an edge SHALL force state=HUNT, prev=0, wrap_pulse=0, wrap_count=0, locked=0, seq_err=0, err_count=0, overriding clr_err and count_in.
REQ-028 rst asserted mid-operation (any state) SHALL take effect at the next edge; first sample after rst deassertion is evaluated in HUNT.

Structure
REQ-029 Shared package count_chk_pkg SHALL hold the state enum, the encoding constants, and constant CNT_RST_VAL=4'hF.
REQ-030 err_count SHALL be built from one sub-module sat_counter (parameterised width, inc/clr inputs, saturating).
REQ-031 Expected-value comparison combinational; no other sub-modules.

Verification
REQ-032 Reset, then count_in 15,0,1..8,0 -> locked high cycle after first 0; wrap_pulse single-cycle after second 0; wrap_count=1; seq_err=0.
REQ-033 Locked, drive 0..8 repeatedly 300 wraps with WRAP_W=8 -> wrap_count=44 (300 mod 256), 300 pulses, no error.
REQ-034 Locked at prev=4, drive 6 -> state=ERROR, seq_err=1, err_count=1; subsequent garbage leaves err_count=1.
REQ-035 Force 20 errors (error, clr_err... repeated without clear between counting via reset-free re-entry) with ERR_W=4 -> err_count saturates at 15; clr_err in ERROR -> HUNT, err_count=0, wrap_count unchanged.
REQ-036 Locked, upstream reset injects 15 -> ERROR; simultaneous clr_err on mismatch edge -> state=ERROR, seq_err=0, err_count=0.
REQ-037 rst pulsed while LOCKED with wrap_count=5 -> all outputs 0, state=HUNT next cycle; 15,15,0 -> locked again.
